ppi_bus_master: RTL and testbench



---
 rtl/ppi_pkg.sv | 25 ++
 rtl/ppi_phase_timer.sv | 30 +++
 rtl/ppi_bus_master.sv | 218 +++++++++++++++++++++
 tb/tb_ppi_bus_master.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppi_pkg.sv
// ppi_pkg: shared constants, state encoding and helpers for the 8255 PPI bus master.
package ppi_pkg;

    // PPI register select values carried on A1:A0
    localparam logic [1:0] PPI_PORT_A = 2'd0;
    localparam logic [1:0] PPI_PORT_B = 2'd1;
    localparam logic [1:0] PPI_PORT_C = 2'd2;
    localparam logic [1:0] PPI_CTRL   = 2'd3;

    // Bit 7 of a control-register write selects mode-set (1) versus bit set/reset (0)
    localparam int PPI_MODE_SET_BIT = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } ppi_state_e;

    // True when a control-register write is a mode-set word
    function automatic logic is_mode_set(input logic [7:0] wdata);
        return wdata[PPI_MODE_SET_BIT];
    endfunction

endpackage

// File: rtl/ppi_phase_timer.sv
// ppi_phase_timer: loadable down-counter whose zero flag marks the last cycle of a
// setup, strobe or hold phase. It stops at zero until it is reloaded.
module ppi_phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_r;

    // Load a new phase length, otherwise count down and park at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/ppi_bus_master.sv
// ppi_bus_master: sequences one 8255 PPI bus cycle (setup, strobe, hold) per accepted
// request and returns a one-cycle response with the read data.
// Optional feature macro: PPI_CTRL_SHADOW_EN -- keeps a shadow of the last mode-set
// control word and answers control-register reads from it without a bus strobe.
module ppi_bus_master
    import ppi_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [1:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic [1:0] a,
    inout  wire  [7:0] d,
    output logic [7:0] ctrl_shadow
);

    // Counter reload values: each phase lasts (value + 1) cycles
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    ppi_state_e       state_r, state_nxt;
    logic             cs_n_r, cs_n_nxt;
    logic             rd_n_r, rd_n_nxt;
    logic             wr_n_r, wr_n_nxt;
    logic [1:0]       a_r, a_nxt;
    logic             d_oe_r, d_oe_nxt;
    logic [7:0]       d_out_r, d_out_nxt;
    logic             wr_r, wr_nxt;
    logic             bus_r, bus_nxt;
    logic             rsp_valid_r, rsp_valid_nxt;
    logic [7:0]       rsp_rdata_r, rsp_rdata_nxt;
    logic             tmr_load_s;
    logic [CNT_W-1:0] tmr_val_s;
    logic             tmr_zero_s;
    logic             req_bus_s;

`ifdef PPI_CTRL_SHADOW_EN
    logic [7:0]       ctrl_shadow_r, ctrl_shadow_nxt;
`endif

    ppi_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .zero     (tmr_zero_s)
    );

    // Decide whether the incoming request needs a real bus strobe
    always_comb begin
`ifdef PPI_CTRL_SHADOW_EN
        req_bus_s = req_write || (req_addr != PPI_CTRL);
`else
        req_bus_s = 1'b1;
`endif
    end

    // Next-state and next-pin computation; every pin is registered below
    always_comb begin
        state_nxt     = state_r;
        cs_n_nxt      = cs_n_r;
        rd_n_nxt      = rd_n_r;
        wr_n_nxt      = wr_n_r;
        a_nxt         = a_r;
        d_oe_nxt      = d_oe_r;
        d_out_nxt     = d_out_r;
        wr_nxt        = wr_r;
        bus_nxt       = bus_r;
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = rsp_rdata_r;
        tmr_load_s    = 1'b0;
        tmr_val_s     = SETUP_LD;
`ifdef PPI_CTRL_SHADOW_EN
        ctrl_shadow_nxt = ctrl_shadow_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    wr_nxt     = req_write;
                    bus_nxt    = req_bus_s;
                    a_nxt      = req_addr;
                    d_out_nxt  = req_wdata;
                    d_oe_nxt   = req_write;
                    cs_n_nxt   = ~req_bus_s;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = SETUP_LD;
                    state_nxt  = ST_SETUP;
                end else begin
                    state_nxt  = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (tmr_zero_s) begin
                    rd_n_nxt   = ~(bus_r & ~wr_r);
                    wr_n_nxt   = ~(bus_r & wr_r);
                    tmr_load_s = 1'b1;
                    tmr_val_s  = STROBE_LD;
                    state_nxt  = ST_STROBE;
                end else begin
                    rd_n_nxt   = 1'b1;
                    wr_n_nxt   = 1'b1;
                end
            end
            ST_STROBE: begin
                if (tmr_zero_s) begin
                    rd_n_nxt   = 1'b1;
                    wr_n_nxt   = 1'b1;
                    if (!wr_r) begin
`ifdef PPI_CTRL_SHADOW_EN
                        rsp_rdata_nxt = bus_r ? d : ctrl_shadow_r;
`else
                        rsp_rdata_nxt = d;
`endif
                    end else begin
                        rsp_rdata_nxt = rsp_rdata_r;
                    end
                    tmr_load_s = 1'b1;
                    tmr_val_s  = HOLD_LD;
                    state_nxt  = ST_HOLD;
                end else begin
                    state_nxt  = ST_STROBE;
                end
            end
            ST_HOLD: begin
                if (tmr_zero_s) begin
                    cs_n_nxt      = 1'b1;
                    d_oe_nxt      = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = ST_IDLE;
`ifdef PPI_CTRL_SHADOW_EN
                    if (wr_r && (a_r == PPI_CTRL) && is_mode_set(d_out_r)) begin
                        ctrl_shadow_nxt = d_out_r;
                    end else begin
                        ctrl_shadow_nxt = ctrl_shadow_r;
                    end
`endif
                end else begin
                    state_nxt     = ST_HOLD;
                end
            end
            default: begin
                cs_n_nxt  = 1'b1;
                rd_n_nxt  = 1'b1;
                wr_n_nxt  = 1'b1;
                d_oe_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and pin registers; reset parks the bus with all strobes inactive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cs_n_r      <= 1'b1;
            rd_n_r      <= 1'b1;
            wr_n_r      <= 1'b1;
            a_r         <= 2'd0;
            d_oe_r      <= 1'b0;
            d_out_r     <= 8'h00;
            wr_r        <= 1'b0;
            bus_r       <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 8'h00;
        end else begin
            state_r     <= state_nxt;
            cs_n_r      <= cs_n_nxt;
            rd_n_r      <= rd_n_nxt;
            wr_n_r      <= wr_n_nxt;
            a_r         <= a_nxt;
            d_oe_r      <= d_oe_nxt;
            d_out_r     <= d_out_nxt;
            wr_r        <= wr_nxt;
            bus_r       <= bus_nxt;
            rsp_valid_r <= rsp_valid_nxt;
            rsp_rdata_r <= rsp_rdata_nxt;
        end
    end

`ifdef PPI_CTRL_SHADOW_EN
    // Shadow of the last mode-set control word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_shadow_r <= 8'h00;
        end else begin
            ctrl_shadow_r <= ctrl_shadow_nxt;
        end
    end

    assign ctrl_shadow = ctrl_shadow_r;
`else
    assign ctrl_shadow = 8'h00;
`endif

    assign req_ready = (state_r == ST_IDLE);
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign cs_n      = cs_n_r;
    assign rd_n      = rd_n_r;
    assign wr_n      = wr_n_r;
    assign a         = a_r;
    assign d         = d_oe_r ? d_out_r : 8'hzz;

endmodule

// File: tb/tb_ppi_bus_master.sv
// tb_ppi_bus_master: two DUT instances (default timing and 3/5/2 timing), each with a
// simple PPI register model on its data bus, checked every cycle against a
// transaction-level model that knows only "cycles since accept".
module tb_ppi_bus_master;

    localparam int IDLE_K = 1000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       req_valid   [2];
    logic       req_write   [2];
    logic [1:0] req_addr    [2];
    logic [7:0] req_wdata   [2];
    logic       req_ready_o [2];
    logic       rsp_valid_o [2];
    logic [7:0] rdata_o     [2];
    logic       cs_n_o      [2];
    logic       rd_n_o      [2];
    logic       wr_n_o      [2];
    logic [1:0] a_o         [2];
    logic [7:0] shadow_o    [2];
    logic [7:0] regs        [2][4];
    wire  [7:0] d0;
    wire  [7:0] d1;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // PPI side: a port register is driven only while selected and read-strobed
    assign d0 = (!cs_n_o[0] && !rd_n_o[0]) ? regs[0][a_o[0]] : 8'hzz;
    assign d1 = (!cs_n_o[1] && !rd_n_o[1]) ? regs[1][a_o[1]] : 8'hzz;

    ppi_bus_master dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready_o[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid_o[0]), .rsp_rdata(rdata_o[0]), .cs_n(cs_n_o[0]),
        .rd_n(rd_n_o[0]), .wr_n(wr_n_o[0]), .a(a_o[0]), .d(d0), .ctrl_shadow(shadow_o[0])
    );

    ppi_bus_master #(.SETUP_CYC(3), .STROBE_CYC(5), .HOLD_CYC(2), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready_o[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid_o[1]), .rsp_rdata(rdata_o[1]), .cs_n(cs_n_o[1]),
        .rd_n(rd_n_o[1]), .wr_n(wr_n_o[1]), .a(a_o[1]), .d(d1), .ctrl_shadow(shadow_o[1])
    );

    function automatic int sp(input int i); return (i == 0) ? 1 : 3; endfunction
    function automatic int tp(input int i); return (i == 0) ? 2 : 5; endfunction
    function automatic int lp(input int i); return (i == 0) ? 4 : 10; endfunction
    function automatic logic [7:0] dv(input int i); return (i == 0) ? d0 : d1; endfunction

    function automatic bit exp_bus(input logic wr, input logic [1:0] ad);
`ifdef PPI_CTRL_SHADOW_EN
        return wr || (ad != 2'd3);
`else
        return 1'b1;
`endif
    endfunction

    // Reference model: per instance, the captured request and cycles since its accept
    int         mk       [2] = '{IDLE_K, IDLE_K};
    logic       m_wr     [2];
    logic [1:0] m_addr   [2];
    logic [7:0] m_wd     [2];
    bit         m_bus    [2];
    logic [7:0] m_rdata  [2] = '{8'h00, 8'h00};
    logic [7:0] m_shadow [2] = '{8'h00, 8'h00};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mk[i]       <= IDLE_K;
                m_rdata[i]  <= 8'h00;
                m_shadow[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (mk[i] < lp(i)) begin
                    if ((mk[i] + 1 == sp(i) + tp(i)) && !m_wr[i])
                        m_rdata[i] <= m_bus[i] ? regs[i][m_addr[i]] : m_shadow[i];
`ifdef PPI_CTRL_SHADOW_EN
                    if ((mk[i] + 1 == lp(i)) && m_wr[i] && (m_addr[i] == 2'd3) && m_wd[i][7])
                        m_shadow[i] <= m_wd[i];
`endif
                end
                if ((mk[i] >= lp(i)) && req_valid[i]) begin
                    mk[i]     <= 0;
                    m_wr[i]   <= req_write[i];
                    m_addr[i] <= req_addr[i];
                    m_wd[i]   <= req_wdata[i];
                    m_bus[i]  <= exp_bus(req_write[i], req_addr[i]);
                end else if (mk[i] < IDLE_K) begin
                    mk[i] <= mk[i] + 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d] at %0t: actual=%0h required=%0h", nm, i, $time, act, exp);
        end
    endtask

    task automatic check_cycle(input int i);
        int k   = mk[i];
        bit act = (k < lp(i));
        bit stb = m_bus[i] && act && (k >= sp(i)) && (k < sp(i) + tp(i));
        chk("cs_n", i, cs_n_o[i], !(act && m_bus[i]));
        chk("rd_n", i, rd_n_o[i], !(stb && !m_wr[i]));
        chk("wr_n", i, wr_n_o[i], !(stb && m_wr[i]));
        chk("req_ready", i, req_ready_o[i], k >= lp(i));
        chk("rsp_valid", i, rsp_valid_o[i], k == lp(i));
        chk("rsp_rdata", i, rdata_o[i], m_rdata[i]);
        chk("ctrl_shadow", i, shadow_o[i], m_shadow[i]);
        if (act && m_bus[i]) chk("a", i, a_o[i], m_addr[i]);
        if (act && m_wr[i]) chk("d_write", i, dv(i), m_wd[i]);
        if (stb && !m_wr[i]) chk("d_read", i, dv(i), regs[i][m_addr[i]]);
    endtask

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            for (int i = 0; i < 2; i++) check_cycle(i);
        end
    end

    task automatic wait_ready(input int i);
        int n = 0;
        while (!req_ready_o[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", i, 32'd1, 32'd0);
    endtask

    // One isolated transaction, observing pin timing relative to the accept edge
    task automatic measure(input int i, input logic wr, input logic [1:0] ad, input logic [7:0] wd,
                           output int lat, output int cs_low, output int st_low,
                           output int st_first, output logic [7:0] rd);
        @(negedge clk);
        req_valid[i] = 1'b1; req_write[i] = wr; req_addr[i] = ad; req_wdata[i] = wd;
        wait_ready(i);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0; req_write[i] = ~wr; req_addr[i] = ~ad; req_wdata[i] = ~wd;
        lat = -1; cs_low = 0; st_low = 0; st_first = -1; rd = 8'h00;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            @(negedge clk);
            if (!cs_n_o[i]) cs_low++;
            if (!rd_n_o[i] || !wr_n_o[i]) begin
                st_low++;
                if (st_first < 0) st_first = k;
            end
            if (rsp_valid_o[i]) begin
                lat = k;
                rd  = rdata_o[i];
            end
        end
    endtask

    initial begin
        int lat, csl, stl, stf, gap;
        bit acc_rsp;
        logic [7:0] rd;

        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = 2'd0; req_wdata[i] = 8'h00;
            for (int r = 0; r < 4; r++) regs[i][r] = 8'h00;
        end
        regs[0][0] = 8'h3C;
        regs[0][2] = 8'h5A;
        #1 rst_n = 1'b0;
        #2;
        for (int i = 0; i < 2; i++) begin
            chk("rst_cs_n", i, cs_n_o[i], 1'b1);
            chk("rst_rd_n", i, rd_n_o[i], 1'b1);
            chk("rst_wr_n", i, wr_n_o[i], 1'b1);
            chk("rst_a", i, a_o[i], 2'd0);
            chk("rst_rsp_valid", i, rsp_valid_o[i], 1'b0);
            chk("rst_rsp_rdata", i, rdata_o[i], 8'h00);
            chk("rst_ctrl_shadow", i, shadow_o[i], 8'h00);
            chk("rst_req_ready", i, req_ready_o[i], 1'b1);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Write 8'hA5 to port B with default timing
        measure(0, 1'b1, 2'd1, 8'hA5, lat, csl, stl, stf, rd);
        chk("wr_latency", 0, lat, 4);
        chk("wr_cs_low", 0, csl, 4);
        chk("wr_strobe_low", 0, stl, 2);
        chk("wr_strobe_start", 0, stf, 1);

        // Read port A while the PPI returns 8'h3C
        measure(0, 1'b0, 2'd0, 8'h00, lat, csl, stl, stf, rd);
        chk("rd_latency", 0, lat, 4);
        chk("rd_strobe_low", 0, stl, 2);
        chk("rd_data", 0, rd, 8'h3C);
        chk("model_rdata", 0, m_rdata[0], 8'h3C);

        // Stretched timing instance
        measure(1, 1'b1, 2'd2, 8'h77, lat, csl, stl, stf, rd);
        chk("long_latency", 1, lat, 10);
        chk("long_cs_low", 1, csl, 10);
        chk("long_strobe_low", 1, stl, 5);
        chk("long_strobe_start", 1, stf, 3);

        // Back-to-back: write 8'h80 to control, then read port C with valid held high
        @(negedge clk);
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 2'd3; req_wdata[0] = 8'h80;
        wait_ready(0);
        @(posedge clk);
        #1;
        req_write[0] = 1'b0; req_addr[0] = 2'd2;
        gap = 0; acc_rsp = 1'b0;
        for (int k = 0; k < 40 && !acc_rsp; k++) begin
            @(negedge clk);
            if (cs_n_o[0]) gap++;
            if (rsp_valid_o[0] && req_ready_o[0]) acc_rsp = 1'b1;
        end
        chk("b2b_accept_in_rsp", 0, acc_rsp, 1'b1);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        if (cs_n_o[0]) gap++;
        chk("b2b_cs_gap", 0, gap, 1);
        lat = -1;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            @(negedge clk);
            if (rsp_valid_o[0]) begin
                lat = k;
                chk("b2b_rdata", 0, rdata_o[0], 8'h5A);
            end
        end
        chk("b2b_second_latency", 0, lat, 3);

        // Reset during the write strobe
        @(negedge clk);
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 2'd0; req_wdata[0] = 8'h3E;
        wait_ready(0);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_wr_n", 0, wr_n_o[0], 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_cs_n", 0, cs_n_o[0], 1'b1);
        chk("mid_rst_wr_n", 0, wr_n_o[0], 1'b1);
        chk("mid_rst_rd_n", 0, rd_n_o[0], 1'b1);
        chk("mid_rst_rsp_valid", 0, rsp_valid_o[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("post_rst_ready", 0, req_ready_o[0], 1'b1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", 0, rsp_valid_o[0], 1'b0);
        end

        // Randomized traffic, inputs churn every cycle including mid-transaction
        for (int i = 0; i < 2; i++)
            for (int r = 0; r < 4; r++) regs[i][r] = 8'($urandom);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                req_valid[i] = ($urandom_range(0, 3) != 0);
                req_write[i] = 1'($urandom_range(0, 1));
                req_addr[i]  = 2'($urandom_range(0, 3));
                req_wdata[i] = 8'($urandom);
            end
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) req_valid[i] = 1'b0;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
